// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch unit.
`default_nettype none

package instr_fetch_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
// Synchronous {pc,instr} queue with push/pop/flush; pointers wrap modulo DEPTH.
`default_nettype none

module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  storage [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            storage[wr_ptr] <= push_entry;
        end
    end

    assign head = storage[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// RV32I fetch unit: PC/credit/drop bookkeeping, memory request issue and decode handoff.
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_raw,
    output logic [31:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic          run;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [CW:0]   in_use;
    logic          req_fire;
    logic          rsp_accept;
    logic          push;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        run            = 1'b0;
        imem_req_valid = 1'b0;
        case (state)
            FETCH_BOOT: state_next = FETCH_RUN;
            FETCH_RUN: begin
                run            = 1'b1;
                imem_req_valid = !redirect && (in_use < (CW + 1)'(FIFO_DEPTH));
            end
            default: state_next = FETCH_BOOT;
        endcase
    end

    // Credits cover both in-flight requests and queued words, so the queue never overflows.
    assign in_use     = {1'b0, outstanding} + {1'b0, count};
    assign req_fire   = imem_req_valid && imem_req_ready;
    assign rsp_accept = run && imem_rsp_valid;
    assign push       = rsp_accept && (drop == '0) && !redirect;
    assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};
    assign pop        = instr_valid && instr_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect) begin
            // Every response still in flight belongs to the abandoned path.
            fetch_pc    <= word_align(redirect_pc);
            rsp_pc      <= word_align(redirect_pc);
            outstanding <= outstanding - CW'(rsp_accept);
            drop        <= outstanding - CW'(rsp_accept);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_accept);
            if (rsp_accept && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
        end
    end

    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .count      (count)
    );

    assign imem_req_addr = fetch_pc;
    assign instr_valid   = (count != '0) && !redirect;
    assign instr_raw     = instr_valid ? head.instr : INSTR_NOP;
    assign instr_pc      = instr_valid ? head.pc : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch with an in-bench memory and program-order model.
`default_nettype none

module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_raw;
    logic [31:0] instr_pc;

    instr_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_raw      (instr_raw),
        .instr_pc       (instr_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mreq_t       mq[$];
    exp_t        exp_q[$];
    logic [31:0] redir_q[$];
    int          checks, errors, cyc, nfire, nhand;
    int unsigned p_ready, p_iready, p_rsp, p_redir, lat_min, lat_max;
    bit          mon_en, capture_first, prev_wait;
    logic [31:0] req_pc, salt, first_pc, prev_addr;
    exp_t        mon_e;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ salt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock of stimulus: memory model, decode backpressure and redirects.
    task automatic cycle();
        int lat;
        @(negedge clock);
        imem_req_ready = ($urandom_range(99) < p_ready);
        instr_ready    = ($urandom_range(99) < p_iready);
        if (redir_q.size() > 0) begin
            redirect    = 1'b1;
            redirect_pc = redir_q.pop_front();
        end else begin
            redirect    = ($urandom_range(99) < p_redir);
            redirect_pc = $urandom;
        end
        if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (redirect) begin
            exp_q.delete();
            req_pc = {redirect_pc[31:2], 2'b00};
            chk("req_valid_on_redirect", 32'(imem_req_valid), 32'd0);
        end else if (prev_wait) begin
            chk("req_held_valid", 32'(imem_req_valid), 32'd1);
            chk("req_held_addr", imem_req_addr, prev_addr);
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, req_pc);
            lat = int'($urandom_range(lat_max, lat_min));
            mq.push_back('{imem_req_addr, cyc + lat});
            exp_q.push_back('{imem_req_addr, memf(imem_req_addr)});
            req_pc = req_pc + 32'd4;
            nfire++;
        end
        prev_wait = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
        chk("outstanding_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
        cyc++;
    endtask

    // Monitor: pops the expected program-order stream on every decode handoff.
    always @(negedge clock) begin
        if (mon_en) begin
            #2;
            if (instr_valid && instr_ready) begin
                nhand++;
                if (capture_first) begin
                    first_pc      = instr_pc;
                    capture_first = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL handoff_unexpected actual pc=%h required none", instr_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("instr_pc", instr_pc, mon_e.pc);
                    chk("instr_raw", instr_raw, mon_e.instr);
                end
            end else if (!instr_valid) begin
                chk("idle_raw", instr_raw, NOP);
                chk("idle_pc", instr_pc, 32'h0);
            end
        end
    end

    task automatic knobs(input int unsigned rd, input int unsigned ir, input int unsigned rs,
                         input int unsigned rdir, input int unsigned lmin, input int unsigned lmax);
        p_ready = rd; p_iready = ir; p_rsp = rs; p_redir = rdir; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic quiet_inputs();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("boot_req_valid", 32'(imem_req_valid), 32'd0);
        mq.delete(); exp_q.delete(); redir_q.delete();
        req_pc = RST_PC; prev_wait = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        int f0, h0;
        checks = 0; errors = 0; cyc = 0; nfire = 0; nhand = 0;
        mon_en = 1'b0; capture_first = 1'b0; prev_wait = 1'b0; first_pc = 32'h0;
        prev_addr = 32'h0; salt = $urandom; req_pc = RST_PC;
        quiet_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_raw", instr_raw, NOP);
        chk("rst_instr_pc", instr_pc, 32'h0);
        release_reset();

        // Decode stalled from boot: credits allow exactly DEPTH requests; PC wraps past 0xFFFFFFFC.
        knobs(100, 0, 100, 0, 1, 1);
        f0 = nfire;
        repeat (10) cycle();
        chk("stall_fire_count", 32'(nfire - f0), 32'(DEPTH));
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        knobs(100, 100, 100, 0, 1, 1);
        h0 = nhand;
        repeat (20) cycle();
        chk("stall_release_delivers", 32'((nhand - h0) >= DEPTH), 32'd1);

        // Redirect with two requests in flight at 3-cycle latency.
        knobs(100, 100, 100, 0, 3, 3);
        for (int i = 0; i < 20 && mq.size() < 2; i++) cycle();
        chk("two_outstanding", 32'(mq.size() >= 2), 32'd1);
        redir_q.push_back(32'h0000_0200);
        cycle();
        capture_first = 1'b1;
        repeat (15) cycle();
        chk("first_pc_after_redirect", first_pc, 32'h0000_0200);

        // Unaligned target, then two back-to-back redirects.
        knobs(100, 100, 100, 0, 1, 2);
        redir_q.push_back(32'h0000_0203);
        cycle();
        cycle();
        chk("redirect_align", imem_req_addr, 32'h0000_0200);
        repeat (5) cycle();
        redir_q.push_back(32'h0000_0300);
        redir_q.push_back(32'h0000_0400);
        cycle();
        cycle();
        capture_first = 1'b1;
        repeat (15) cycle();
        chk("last_redirect_wins", first_pc, 32'h0000_0400);

        // Randomized traffic.
        knobs(70, 70, 80, 4, 1, 4);
        h0 = nhand;
        repeat (600) cycle();
        chk("random_progress", 32'(nhand > h0), 32'd1);

        // Fill the queue, then reset asynchronously mid-stream.
        knobs(100, 0, 100, 0, 1, 1);
        repeat (12) cycle();
        chk("prefill_instr_valid", 32'(instr_valid), 32'd1);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr_raw", instr_raw, NOP);
        chk("mid_rst_instr_pc", instr_pc, 32'h0);
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_rst_req_addr", imem_req_addr, RST_PC);
        quiet_inputs();
        repeat (2) @(posedge clock);
        release_reset();
        knobs(100, 100, 100, 0, 1, 2);
        f0 = nfire;
        cycle();
        chk("first_req_after_reset", 32'(nfire - f0), 32'd1);
        h0 = nhand;
        repeat (20) cycle();
        chk("post_reset_progress", 32'(nhand > h0), 32'd1);

        @(negedge clock);
        mon_en = 1'b0;
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
